hazard_ctrl_unit: RTL

- Hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB), with branch resolution and operand read in ID.
- Consumes per-instruction decode hazard info from the ID stage: rs1/rs2 use flags, register indices, destination register and hazard optype.
- Tracks in-flight producers in EX/MEM/WB and generates:
  - ID-stage forwarding selects
  - load-use stalls
  - branch flushes
  - pipeline-register enables
  - store-data forwarding for load→store pairs

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 41 ++++
 rtl/hazard_ctrl_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared encodings for the pipeline hazard controller.
//   - optype_t : hazard optype carried by each instruction (NONE/ALU/LOAD/STORE)
//   - fwd_t    : ID-stage operand forward select
//   - is_producer(): true when a stage record writes a register that can be forwarded
package hazard_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } optype_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EX    = 2'd1,
        FWD_MEM   = 2'd2,
        FWD_MEMLD = 2'd3
    } fwd_t;

    // Register x0 is hard-wired, so a record with rd==0 never produces.
    function automatic logic is_producer(input optype_t op, input logic rd_nonzero);
        return ((op == OP_ALU) || (op == OP_LOAD)) && rd_nonzero;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel
//   Combinational forward selector for one ID-stage source operand.
//   Ports:
//     rs_use, rs        : operand is read / its register index
//     ex_op, ex_rd      : producer record currently in EX
//     mem_op, mem_rd    : producer record currently in MEM
//     fwd               : selected operand source (FWD_RF/EX/MEM/MEMLD)
//   WB never needs a bypass because the register file writes before it reads.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              rs_use,
    input  logic [REG_AW-1:0] rs,
    input  optype_t           ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  optype_t           mem_op,
    input  logic [REG_AW-1:0] mem_rd,
    output fwd_t              fwd
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = rs_use && (rs == ex_rd)  && is_producer(ex_op,  ex_rd  != '0);
        mem_hit = rs_use && (rs == mem_rd) && is_producer(mem_op, mem_rd != '0);

        fwd = FWD_RF;
        // A load still in EX has no data yet; that case is handled by the
        // load-use stall, so it falls through to the MEM checks here.
        if (ex_hit && (ex_op == OP_ALU))
            fwd = FWD_EX;
        else if (mem_hit && (mem_op == OP_ALU))
            fwd = FWD_MEM;
        else if (mem_hit && (mem_op == OP_LOAD))
            fwd = FWD_MEMLD;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard controller for a 5-stage RV32I pipeline with branch resolution
//   and operand read in ID. Tracks producer records in EX/MEM/WB and drives
//   forwarding selects, load-use stalls, branch flushes and pipeline enables.
//   Ports:
//     clk, rst                       : clock, async active-high reset
//     rs1use_ID/rs2use_ID, rs1_ID/rs2_ID, rd_ID, hazard_optype_ID
//                                    : ID-stage decode hazard info
//     Branch_ID                      : redirect taken in ID
//     mem_busy                       : external memory stall, freezes the pipe
//     forward_ctrl_A/B               : rs1/rs2 forward selects
//     forward_ctrl_ls                : MEM store takes data from WB load result
//     PC_EN_IF, reg_*_EN, reg_*_flush: pipeline register controls
//     stall_cnt, flush_cnt           : perf counters
//   Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
//   counters; otherwise they read as zero and no counter flops exist.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              Branch_ID,
    input  logic              mem_busy,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_EN,
    output logic              reg_DE_flush,
    output logic              reg_EM_EN,
    output logic              reg_MW_EN,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    optype_t           id_op;
    optype_t           ex_op,  mem_op,  wb_op;
    logic [REG_AW-1:0] ex_rd,  mem_rd,  wb_rd;
    logic              ex_lsp, mem_lsp, wb_lsp;

    logic ex_load;
    logic rs1_haz;
    logic rs2_haz;
    logic load_use;
    logic id_lsp;
    fwd_t fwd_a;
    fwd_t fwd_b;

    assign id_op = optype_t'(hazard_optype_ID);

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_use (rs1use_ID),
        .rs     (rs1_ID),
        .ex_op  (ex_op),
        .ex_rd  (ex_rd),
        .mem_op (mem_op),
        .mem_rd (mem_rd),
        .fwd    (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_use (rs2use_ID),
        .rs     (rs2_ID),
        .ex_op  (ex_op),
        .ex_rd  (ex_rd),
        .mem_op (mem_op),
        .mem_rd (mem_rd),
        .fwd    (fwd_b)
    );

    always_comb begin
        ex_load  = (ex_op == OP_LOAD) && (ex_rd != '0);
        rs1_haz  = ex_load && rs1use_ID && (rs1_ID == ex_rd);
        rs2_haz  = ex_load && rs2use_ID && (rs2_ID == ex_rd);
        // A store only needs the loaded value as write data in MEM, so it can
        // proceed and pick the data up from WB later; an rs1 (address) hazard
        // still stalls.
        load_use = rs1_haz || (rs2_haz && (id_op != OP_STORE));
        id_lsp   = (id_op == OP_STORE) && rs2_haz && !rs1_haz;

        forward_ctrl_A  = fwd_a;
        forward_ctrl_B  = fwd_b;
        // Load and store advance in lockstep, so a pending store in MEM always
        // has its load in WB; a load record never carries ls_pend.
        forward_ctrl_ls = (mem_op == OP_STORE) && mem_lsp &&
                          (wb_op == OP_LOAD) && (wb_rd != '0) && !wb_lsp;

        PC_EN_IF     = !mem_busy && !load_use;
        reg_FD_EN    = !mem_busy && !load_use;
        reg_FD_flush = !mem_busy && !load_use && Branch_ID;
        reg_DE_EN    = !mem_busy;
        reg_DE_flush = !mem_busy && load_use;
        reg_EM_EN    = !mem_busy;
        reg_MW_EN    = !mem_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op   <= OP_NONE;
            ex_rd   <= '0;
            ex_lsp  <= 1'b0;
            mem_op  <= OP_NONE;
            mem_rd  <= '0;
            mem_lsp <= 1'b0;
            wb_op   <= OP_NONE;
            wb_rd   <= '0;
            wb_lsp  <= 1'b0;
        end else if (!mem_busy) begin
            wb_op   <= mem_op;
            wb_rd   <= mem_rd;
            wb_lsp  <= mem_lsp;
            mem_op  <= ex_op;
            mem_rd  <= ex_rd;
            mem_lsp <= ex_lsp;
            if (load_use) begin
                ex_op  <= OP_NONE;
                ex_rd  <= '0;
                ex_lsp <= 1'b0;
            end else begin
                ex_op  <= id_op;
                ex_rd  <= rd_ID;
                ex_lsp <= id_lsp;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (reg_DE_flush)
                stall_cnt <= stall_cnt + 1'b1;
            if (reg_FD_flush)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
